// File: rtl/sha256_ctrl_pkg.sv
// sha256_ctrl_pkg: shared state encoding, default sizes and index-width helper for the SHA-256 stream controller.
package sha256_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUND  = 3'd2,
        ST_FINAL  = 3'd3,
        ST_OUTPUT = 3'd4
    } ctrl_state_t;

    localparam int SHA256_ROUNDS       = 64;
    localparam int SHA256_LOAD_WORDS   = 16;
    localparam int SHA256_DIGEST_WORDS = 8;

    // A single-entry index still needs a 1-bit port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrl_idx_counter.sv
// ctrl_idx_counter: wrapping index counter with enable, synchronous clear and terminal-count flag.
module ctrl_idx_counter #(
    parameter int W    = 4,
    parameter int TERM = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_term
);

    logic [W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == W'(TERM));

    always_ff @(posedge clk) begin
        if (!reset || i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= o_term ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/sha256_stream_ctrl.sv
// sha256_stream_ctrl: sequences multi-block messages through load, rounds, feed-forward and digest readout.
module sha256_stream_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter int ROUNDS      = SHA256_ROUNDS,
    parameter int LOAD_CYCLES = SHA256_LOAD_WORDS,
    parameter int OUT_BEATS   = SHA256_DIGEST_WORDS,
    parameter int BLK_CNT_W   = 16,
    localparam int LIW = idx_w(LOAD_CYCLES),
    localparam int RIW = idx_w(ROUNDS),
    localparam int OIW = idx_w(OUT_BEATS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 load_en,
    output logic [LIW-1:0]       load_idx,
    output logic                 round_en,
    output logic [RIW-1:0]       round_idx,
    output logic                 init_hash,
    output logic                 ff_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OIW-1:0]       out_idx,
    output logic                 busy,
    output logic [BLK_CNT_W-1:0] blk_count,
    output logic                 err_proto
);

    ctrl_state_t          r_state;
    logic                 r_is_first;
    logic                 r_is_last;
    logic [BLK_CNT_W-1:0] r_blk;
    logic                 r_err;

    logic           w_run, w_in_ready, w_load_en, w_round_en, w_out_valid, w_out_acc;
    logic           w_lterm, w_rterm, w_oterm;
    logic [LIW-1:0] w_lidx;
    logic [RIW-1:0] w_ridx;
    logic [OIW-1:0] w_oidx;

    // Reset and abort both mask every handshake/enable so nothing leaks out in those cycles.
    assign w_run       = reset && !abort;
    assign w_in_ready  = w_run && (r_state == ST_IDLE || r_state == ST_LOAD);
    assign w_load_en   = w_in_ready && in_valid;
    assign w_round_en  = w_run && (r_state == ST_ROUND);
    assign w_out_valid = w_run && (r_state == ST_OUTPUT);
    assign w_out_acc   = w_out_valid && out_ready;

    ctrl_idx_counter #(.W(LIW), .TERM(LOAD_CYCLES - 1)) u_load_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (abort),
        .i_en   (w_load_en && (r_state == ST_LOAD || in_first)),
        .o_cnt  (w_lidx),
        .o_term (w_lterm)
    );

    ctrl_idx_counter #(.W(RIW), .TERM(ROUNDS - 1)) u_round_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (abort),
        .i_en   (w_round_en),
        .o_cnt  (w_ridx),
        .o_term (w_rterm)
    );

    ctrl_idx_counter #(.W(OIW), .TERM(OUT_BEATS - 1)) u_out_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (abort),
        .i_en   (w_out_acc),
        .o_cnt  (w_oidx),
        .o_term (w_oterm)
    );

    assign in_ready  = w_in_ready;
    assign load_en   = w_load_en;
    assign load_idx  = w_run ? w_lidx : '0;
    assign round_en  = w_round_en;
    assign round_idx = w_run ? w_ridx : '0;
    assign init_hash = w_round_en && (w_ridx == '0) && r_is_first;
    assign ff_en     = w_run && (r_state == ST_FINAL);
    assign out_valid = w_out_valid;
    assign out_idx   = w_run ? w_oidx : '0;
    assign busy      = reset && (r_state != ST_IDLE);
    assign blk_count = reset ? r_blk : '0;
    assign err_proto = reset && r_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_is_first <= 1'b0;
            r_is_last  <= 1'b0;
            r_blk      <= '0;
            r_err      <= 1'b0;
        end else if (abort) begin
            r_state    <= ST_IDLE;
            r_is_first <= 1'b0;
            r_is_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load_en && in_first) begin
                        r_state    <= ST_LOAD;
                        r_blk      <= '0;
                        r_is_first <= 1'b1;
                        r_is_last  <= in_last;
                    end else if (w_load_en) begin
                        r_err <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Word 0 of a continuation block may illegally restart the message.
                    if (w_load_en && w_lidx == '0) begin
                        r_is_last <= in_last;
                        if (in_first) begin
                            r_err      <= 1'b1;
                            r_blk      <= '0;
                            r_is_first <= 1'b1;
                        end
                    end
                    if (w_load_en && w_lterm) r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (w_rterm) r_state <= ST_FINAL;
                end
                ST_FINAL: begin
                    r_blk      <= (&r_blk) ? r_blk : r_blk + 1'b1;
                    r_is_first <= 1'b0;
                    r_state    <= r_is_last ? ST_OUTPUT : ST_LOAD;
                end
                ST_OUTPUT: begin
                    if (w_out_acc && w_oterm) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// tb_sha256_stream_ctrl: table-driven check of a small-parameter instance plus directed sequences on a default instance.
module tb_sha256_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Small instance: ROUNDS=4, LOAD_CYCLES=2, OUT_BEATS=1
    logic        s_reset, s_abort, s_in_valid, s_in_first, s_in_last, s_out_ready;
    logic        s_in_ready, s_load_en, s_round_en, s_init_hash, s_ff_en, s_out_valid, s_busy, s_err;
    logic [0:0]  s_load_idx, s_out_idx;
    logic [1:0]  s_round_idx;
    logic [15:0] s_blk;

    sha256_stream_ctrl #(.ROUNDS(4), .LOAD_CYCLES(2), .OUT_BEATS(1), .BLK_CNT_W(16)) u_small (
        .clk(clk), .reset(s_reset), .abort(s_abort), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_first(s_in_first), .in_last(s_in_last), .load_en(s_load_en), .load_idx(s_load_idx),
        .round_en(s_round_en), .round_idx(s_round_idx), .init_hash(s_init_hash), .ff_en(s_ff_en),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_idx(s_out_idx), .busy(s_busy),
        .blk_count(s_blk), .err_proto(s_err)
    );

    // Default instance
    logic        d_reset, d_abort, d_in_valid, d_in_first, d_in_last, d_out_ready;
    logic        d_in_ready, d_load_en, d_round_en, d_init_hash, d_ff_en, d_out_valid, d_busy, d_err;
    logic [3:0]  d_load_idx;
    logic [5:0]  d_round_idx;
    logic [2:0]  d_out_idx;
    logic [15:0] d_blk;

    sha256_stream_ctrl u_dflt (
        .clk(clk), .reset(d_reset), .abort(d_abort), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_first(d_in_first), .in_last(d_in_last), .load_en(d_load_en), .load_idx(d_load_idx),
        .round_en(d_round_en), .round_idx(d_round_idx), .init_hash(d_init_hash), .ff_en(d_ff_en),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_idx(d_out_idx), .busy(d_busy),
        .blk_count(d_blk), .err_proto(d_err)
    );

    // in = {reset, abort, in_valid, in_first, in_last, out_ready}
    // ctl = {in_ready, load_en, load_idx, round_en, round_idx[1:0], init_hash, ff_en, out_valid, out_idx, busy}
    typedef struct {
        logic [5:0]  in;
        logic [10:0] ctl;
        logic [15:0] blk;
        logic        err;
    } vec_t;

    vec_t tbl[30];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    task automatic dcyc(input logic iv, input logic fi, input logic la, input logic ordy, input logic ab);
        @(negedge clk);
        d_in_valid  = iv;
        d_in_first  = fi;
        d_in_last   = la;
        d_out_ready = ordy;
        d_abort     = ab;
        #2;
    endtask

    initial begin
        int nih, nff;
        {s_reset, s_abort, s_in_valid, s_in_first, s_in_last, s_out_ready} = 6'b0;
        {d_reset, d_abort, d_in_valid, d_in_first, d_in_last, d_out_ready} = 6'b0;

        tbl[0]  = '{6'b000000, 11'b00000000000, 16'd0, 1'b0};
        tbl[1]  = '{6'b101110, 11'b11000000000, 16'd0, 1'b0};
        tbl[2]  = '{6'b001000, 11'b00000000000, 16'd0, 1'b0};
        tbl[3]  = '{6'b101111, 11'b11000000000, 16'd0, 1'b0};
        tbl[4]  = '{6'b101001, 11'b11100000001, 16'd0, 1'b0};
        tbl[5]  = '{6'b100001, 11'b00010010001, 16'd0, 1'b0};
        tbl[6]  = '{6'b100001, 11'b00010100001, 16'd0, 1'b0};
        tbl[7]  = '{6'b100001, 11'b00011000001, 16'd0, 1'b0};
        tbl[8]  = '{6'b100001, 11'b00011100001, 16'd0, 1'b0};
        tbl[9]  = '{6'b100001, 11'b00000001001, 16'd0, 1'b0};
        tbl[10] = '{6'b100001, 11'b00000000101, 16'd1, 1'b0};
        tbl[11] = '{6'b100001, 11'b10000000000, 16'd1, 1'b0};
        tbl[12] = '{6'b101001, 11'b11000000000, 16'd1, 1'b0};
        tbl[13] = '{6'b100001, 11'b10000000000, 16'd1, 1'b1};
        tbl[14] = '{6'b101101, 11'b11000000000, 16'd1, 1'b1};
        tbl[15] = '{6'b100001, 11'b10100000001, 16'd0, 1'b1};
        tbl[16] = '{6'b101001, 11'b11100000001, 16'd0, 1'b1};
        tbl[17] = '{6'b100001, 11'b00010010001, 16'd0, 1'b1};
        tbl[18] = '{6'b100001, 11'b00010100001, 16'd0, 1'b1};
        tbl[19] = '{6'b110001, 11'b00000000001, 16'd0, 1'b1};
        tbl[20] = '{6'b100001, 11'b10000000000, 16'd0, 1'b1};
        tbl[21] = '{6'b101111, 11'b11000000000, 16'd0, 1'b1};
        tbl[22] = '{6'b101001, 11'b11100000001, 16'd0, 1'b1};
        tbl[23] = '{6'b100001, 11'b00010010001, 16'd0, 1'b1};
        tbl[24] = '{6'b100001, 11'b00010100001, 16'd0, 1'b1};
        tbl[25] = '{6'b100001, 11'b00011000001, 16'd0, 1'b1};
        tbl[26] = '{6'b100001, 11'b00011100001, 16'd0, 1'b1};
        tbl[27] = '{6'b100001, 11'b00000001001, 16'd0, 1'b1};
        tbl[28] = '{6'b110001, 11'b00000000001, 16'd1, 1'b1};
        tbl[29] = '{6'b100001, 11'b10000000000, 16'd1, 1'b1};

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            {s_reset, s_abort, s_in_valid, s_in_first, s_in_last, s_out_ready} = tbl[i].in;
            #2;
            chk("small_ctl", i, {21'd0, s_in_ready, s_load_en, s_load_idx, s_round_en, s_round_idx,
                s_init_hash, s_ff_en, s_out_valid, s_out_idx, s_busy}, {21'd0, tbl[i].ctl});
            chk("small_blk", i, {16'd0, s_blk}, {16'd0, tbl[i].blk});
            chk("small_err", i, {31'd0, s_err}, {31'd0, tbl[i].err});
        end

        @(negedge clk) d_reset = 1'b0;
        @(negedge clk) d_reset = 1'b1;

        // Single block, no stalls
        for (int c = 0; c <= 89; c++) begin
            dcyc(c < 16, c == 0, 1'b1, 1'b1, 1'b0);
            chk("A_ctl", c, {27'd0, d_load_en, d_init_hash, d_ff_en, d_out_valid, d_busy},
                {27'd0, c < 16, c == 16, c == 80, c >= 81 && c <= 88, c >= 1 && c <= 88});
            if (c < 16) chk("A_load_idx", c, {28'd0, d_load_idx}, c);
            if (c >= 81 && c <= 88) chk("A_out_idx", c, {29'd0, d_out_idx}, c - 81);
        end
        chk("A_blk", 89, {16'd0, d_blk}, 1);

        // Two blocks, 3-cycle gap after word 5 of block 1
        nih = 0;
        nff = 0;
        for (int c = 0; c <= 173; c++) begin
            dcyc(c <= 5 || (c >= 9 && c <= 18) || (c >= 84 && c <= 99), c == 0, c == 84, 1'b1, 1'b0);
            nih += int'(d_init_hash);
            nff += int'(d_ff_en);
            if (c >= 6 && c <= 8) begin
                chk("B_stall_idx", c, {28'd0, d_load_idx}, 6);
                chk("B_stall_hs", c, {30'd0, d_in_ready, d_load_en}, 2);
            end
            if (c == 84) chk("B_blk_mid", c, {16'd0, d_blk}, 1);
            if (c == 164) chk("B_ff2", c, {31'd0, d_ff_en}, 1);
            if (c == 165) chk("B_out_start", c, {31'd0, d_out_valid}, 1);
            if (c == 173) chk("B_idle", c, {31'd0, d_busy}, 0);
        end
        chk("B_init_cnt", 173, nih, 1);
        chk("B_ff_cnt", 173, nff, 2);
        chk("B_blk", 173, {16'd0, d_blk}, 2);

        // out_ready toggling during readout
        for (int c = 0; c <= 97; c++) begin
            dcyc(c < 16, c == 0, 1'b1, (c < 81) || (c % 2 == 0), 1'b0);
            if (c >= 81 && c <= 96) chk("C_out", c, {28'd0, d_out_valid, d_out_idx}, 8 + (c - 81) / 2);
            if (c == 97) chk("C_idle", c, {30'd0, d_busy, d_out_valid}, 0);
        end

        // Stray word in IDLE, then restart inside an active message
        dcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("D_drop", 0, {30'd0, d_load_en, d_busy}, 2);
        dcyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("D_err", 0, {30'd0, d_err, d_busy}, 2);
        nih = 0;
        for (int c = 0; c <= 170; c++) begin
            dcyc(c < 16 || (c >= 81 && c <= 96), c == 0 || c == 81, c == 81, 1'b1, 1'b0);
            nih += int'(d_init_hash);
            if (c == 81) chk("D_blk_pre", c, {16'd0, d_blk}, 1);
            if (c == 82) chk("D_restart", c, {15'd0, d_blk, d_err}, 1);
            if (c == 97) chk("D_init2", c, {31'd0, d_init_hash}, 1);
            if (c == 170) chk("D_end", c, {15'd0, d_blk, d_busy}, 2);
        end
        chk("D_init_cnt", 170, nih, 2);

        // abort in ROUND at round_idx 30
        for (int c = 0; c <= 47; c++) begin
            dcyc(c < 16, c == 0, 1'b1, 1'b1, c == 46);
            if (c == 45) chk("E_r29", c, {25'd0, d_round_en, d_round_idx}, 64 + 29);
            if (c == 46) chk("E_rabort", c, {24'd0, d_round_en, d_round_idx, d_busy}, 1);
            if (c == 47) chk("E_ridle", c, {29'd0, d_in_ready, d_busy, d_round_en}, 4);
        end
        // abort in OUTPUT at out_idx 3
        for (int c = 0; c <= 86; c++) begin
            dcyc(c < 16, c == 0, 1'b1, 1'b1, c == 84);
            if (c == 83) chk("E_o2", c, {28'd0, d_out_valid, d_out_idx}, 8 + 2);
            if (c == 84) chk("E_oabort", c, {30'd0, d_out_valid, d_busy}, 1);
            if (c == 85) chk("E_oidle", c, {29'd0, d_out_valid, d_busy, d_in_ready}, 1);
            if (c == 86) chk("E_quiet", c, {30'd0, d_out_valid, d_round_en}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
